// File: rtl/fetch_controller_pkg.sv
// rtl/fetch_controller_pkg.sv - shared types and constants for the instruction fetch controller
package fetch_controller_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] TRAP_VEC_DEFAULT = 32'h0000_0100;

   typedef enum logic [1:0] {
      REQ   = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2,
      HALT  = 2'd3
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        fault;
   } fetch_pkt_t;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - single-entry valid/ready holding register with flush
module fetch_buffer #(
   parameter int W = 65
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         flush,
   input  logic         out_ready,
   input  logic [W-1:0] load_data,
   output logic         out_valid,
   output logic [W-1:0] out_data
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;

   // Flush wins over load; a load overrides a same-cycle consume.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d = 1'b1;
         data_d  = load_data;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;

endmodule

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - fetch PC owner, one-outstanding imem requester and decode handoff
module fetch_controller
   import fetch_controller_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter logic [XLEN-1:0] TRAP_VEC = TRAP_VEC_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            trap_valid,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] jump_address,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            imem_rsp_err,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_instr,
   output logic            if_fault,
   output logic [XLEN-1:0] pc_out
);

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            run_q, run_d;
   logic            ev, req_valid, accept, buf_load, buf_valid;
   logic [XLEN-1:0] target;
   fetch_pkt_t      load_pkt, out_pkt;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      run_d    = 1'b1;
      buf_load = 1'b0;
      ev       = trap_valid || branch_taken;
      target   = trap_valid ? TRAP_VEC : (jump_address & ~XLEN'(3));
      // run_q holds off the first request until one clean edge after reset.
      req_valid = run_q && (state_q == REQ) && (!buf_valid || if_ready);
      accept    = req_valid && imem_req_ready;

      case (state_q)
         REQ: begin
            if (ev) begin
               pc_d    = target;
               state_d = accept ? DRAIN : REQ;
            end else if (accept) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (ev) begin
               pc_d    = target;
               state_d = imem_rsp_valid ? REQ : DRAIN;
            end else if (imem_rsp_valid) begin
               buf_load = 1'b1;
               if (imem_rsp_err) begin
                  state_d = HALT;
               end else begin
                  pc_d    = pc_q + XLEN'(4);
                  state_d = REQ;
               end
            end
         end
         DRAIN: begin
            if (ev) pc_d = target;
            if (imem_rsp_valid) state_d = REQ;
         end
         HALT: begin
            if (ev) begin
               pc_d    = target;
               state_d = REQ;
            end
         end
         default: state_d = REQ;
      endcase

      load_pkt.pc    = pc_q;
      load_pkt.instr = imem_rsp_data;
      load_pkt.fault = imem_rsp_err;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= REQ;
         pc_q    <= RESET_PC;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         run_q   <= run_d;
      end
   end

   fetch_buffer #(
      .W($bits(fetch_pkt_t))
   ) u_fetch_buffer (
      .clk      (clk),
      .rst      (rst),
      .load     (buf_load),
      .flush    (ev),
      .out_ready(if_ready),
      .load_data(load_pkt),
      .out_valid(buf_valid),
      .out_data (out_pkt)
   );

   assign imem_req_valid = req_valid;
   assign imem_req_addr  = pc_q;
   assign pc_out         = pc_q;
   assign if_valid       = buf_valid;
   assign if_pc          = out_pkt.pc;
   assign if_instr       = out_pkt.instr;
   assign if_fault       = out_pkt.fault;

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - directed table-driven bench for fetch_controller
module tb_fetch_controller;

   logic        clk;
   logic        rst;
   logic        trap_valid;
   logic        branch_taken;
   logic [31:0] jump_address;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        imem_rsp_err;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_fault;
   logic [31:0] pc_out;

   int total = 0;
   int bad   = 0;

   localparam logic [31:0] IB = 32'h1000_0000;

   fetch_controller dut (
      .clk           (clk),
      .rst           (rst),
      .trap_valid    (trap_valid),
      .branch_taken  (branch_taken),
      .jump_address  (jump_address),
      .imem_req_valid(imem_req_valid),
      .imem_req_ready(imem_req_ready),
      .imem_req_addr (imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data (imem_rsp_data),
      .imem_rsp_err  (imem_rsp_err),
      .if_valid      (if_valid),
      .if_ready      (if_ready),
      .if_pc         (if_pc),
      .if_instr      (if_instr),
      .if_fault      (if_fault),
      .pc_out        (pc_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic        rst, trap, br;
      logic [31:0] ja;
      logic        rr, rsv;
      logic [31:0] rsd;
      logic        rse, ir;
      logic        erv;
      logic [31:0] epc;
      logic        eifv;
      logic [31:0] eifpc, einstr;
      logic        ef;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic t, input logic b, input logic [31:0] ja,
                               input logic rr, input logic rsv, input logic [31:0] rsd, input logic rse,
                               input logic ir, input logic erv, input logic [31:0] epc, input logic eifv,
                               input logic [31:0] eifpc, input logic [31:0] einstr, input logic ef);
      vec_t v;
      v.rst = r; v.trap = t; v.br = b; v.ja = ja; v.rr = rr; v.rsv = rsv; v.rsd = rsd; v.rse = rse;
      v.ir = ir; v.erv = erv; v.epc = epc; v.eifv = eifv; v.eifpc = eifpc; v.einstr = einstr; v.ef = ef;
      return v;
   endfunction

   task automatic drive(input logic r, input logic t, input logic b, input logic [31:0] ja,
                        input logic rr, input logic rsv, input logic [31:0] rsd, input logic rse,
                        input logic ir);
      @(negedge clk);
      rst = r; trap_valid = t; branch_taken = b; jump_address = ja;
      imem_req_ready = rr; imem_rsp_valid = rsv; imem_rsp_data = rsd; imem_rsp_err = rse;
      if_ready = ir;
      #2;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, act, exp_v);
      end
   endtask

   vec_t vq[$];

   initial begin
      rst = 1'b1; trap_valid = 1'b0; branch_taken = 1'b0; jump_address = '0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; imem_rsp_err = 1'b0;
      if_ready = 1'b0;
      repeat (2) @(posedge clk);

      //            rst t b  ja            rr rsv rsd                rse ir  erv epc           eifv eifpc        einstr            ef
      vq.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,             0, 1,  0, 32'h0,        0, 32'h0,        32'h0,            0));
      vq.push_back(mk(0, 0, 0, 32'h0,        1, 0, 32'h0,             0, 1,  0, 32'h0,        0, 32'h0,        32'h0,            0));
      vq.push_back(mk(0, 0, 0, 32'h0,        1, 0, 32'h0,             0, 1,  1, 32'h0,        0, 32'h0,        32'h0,            0));
      vq.push_back(mk(0, 0, 0, 32'h0,        1, 1, IB | 32'h0,        0, 1,  0, 32'h0,        0, 32'h0,        32'h0,            0));
      vq.push_back(mk(0, 0, 0, 32'h0,        1, 0, 32'h0,             0, 1,  1, 32'h4,        1, 32'h0,        IB | 32'h0,       0));
      vq.push_back(mk(0, 0, 0, 32'h0,        1, 1, IB | 32'h4,        0, 1,  0, 32'h4,        0, 32'h0,        IB | 32'h0,       0));
      vq.push_back(mk(0, 0, 0, 32'h0,        1, 0, 32'h0,             0, 1,  1, 32'h8,        1, 32'h4,        IB | 32'h4,       0));
      vq.push_back(mk(0, 0, 0, 32'h0,        1, 1, IB | 32'h8,        0, 1,  0, 32'h8,        0, 32'h4,        IB | 32'h4,       0));
      for (int k = 0; k < 5; k++)
         vq.push_back(mk(0, 0, 0, 32'h0,     1, 0, 32'h0,             0, 0,  0, 32'hC,        1, 32'h8,        IB | 32'h8,       0));
      vq.push_back(mk(0, 0, 0, 32'h0,        1, 0, 32'h0,             0, 1,  1, 32'hC,        1, 32'h8,        IB | 32'h8,       0));
      vq.push_back(mk(0, 0, 0, 32'h0,        1, 0, 32'h0,             0, 1,  0, 32'hC,        0, 32'h8,        IB | 32'h8,       0));
      vq.push_back(mk(0, 0, 0, 32'h0,        0, 1, IB | 32'hC,        0, 1,  0, 32'hC,        0, 32'h8,        IB | 32'h8,       0));
      vq.push_back(mk(0, 0, 0, 32'h0,        1, 0, 32'h0,             0, 1,  1, 32'h10,       1, 32'hC,        IB | 32'hC,       0));
      vq.push_back(mk(0, 0, 1, 32'hA2,       1, 0, 32'h0,             0, 1,  0, 32'h10,       0, 32'hC,        IB | 32'hC,       0));
      vq.push_back(mk(0, 0, 0, 32'h0,        0, 1, 32'hDEAD_BEEF,     0, 1,  0, 32'hA0,       0, 32'hC,        IB | 32'hC,       0));
      vq.push_back(mk(0, 0, 0, 32'h0,        1, 0, 32'h0,             0, 1,  1, 32'hA0,       0, 32'hC,        IB | 32'hC,       0));
      vq.push_back(mk(0, 0, 0, 32'h0,        0, 1, IB | 32'hA0,       0, 1,  0, 32'hA0,       0, 32'hC,        IB | 32'hC,       0));
      vq.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,             0, 1,  1, 32'hA4,       1, 32'hA0,       IB | 32'hA0,      0));
      vq.push_back(mk(0, 1, 1, 32'h40,       0, 0, 32'h0,             0, 1,  1, 32'hA4,       0, 32'hA0,       IB | 32'hA0,      0));
      vq.push_back(mk(0, 0, 0, 32'h0,        1, 0, 32'h0,             0, 1,  1, 32'h100,      0, 32'hA0,       IB | 32'hA0,      0));
      vq.push_back(mk(0, 0, 0, 32'h0,        0, 1, IB | 32'h100,      0, 1,  0, 32'h100,      0, 32'hA0,       IB | 32'hA0,      0));
      vq.push_back(mk(0, 0, 0, 32'h0,        1, 0, 32'h0,             0, 0,  0, 32'h104,      1, 32'h100,      IB | 32'h100,     0));
      vq.push_back(mk(0, 0, 1, 32'h13,       1, 0, 32'h0,             0, 0,  0, 32'h104,      1, 32'h100,      IB | 32'h100,     0));
      vq.push_back(mk(0, 0, 0, 32'h0,        1, 0, 32'h0,             0, 1,  1, 32'h10,       0, 32'h100,      IB | 32'h100,     0));

      foreach (vq[i]) begin
         drive(vq[i].rst, vq[i].trap, vq[i].br, vq[i].ja, vq[i].rr, vq[i].rsv, vq[i].rsd, vq[i].rse, vq[i].ir);
         chk($sformatf("v%0d.req_valid", i), 32'(imem_req_valid), 32'(vq[i].erv));
         chk($sformatf("v%0d.req_addr", i), imem_req_addr, vq[i].epc);
         chk($sformatf("v%0d.pc_out", i), pc_out, vq[i].epc);
         chk($sformatf("v%0d.if_valid", i), 32'(if_valid), 32'(vq[i].eifv));
         chk($sformatf("v%0d.if_pc", i), if_pc, vq[i].eifpc);
         chk($sformatf("v%0d.if_instr", i), if_instr, vq[i].einstr);
         chk($sformatf("v%0d.if_fault", i), 32'(if_fault), 32'(vq[i].ef));
      end

      // Access fault at 0x10 parks fetch until a redirect.
      drive(0, 0, 0, 32'h0, 1, 1, IB | 32'h10, 1, 0);
      chk("flt.req_valid_wait", 32'(imem_req_valid), 32'h0);
      drive(0, 0, 0, 32'h0, 1, 0, 32'h0, 0, 1);
      chk("flt.if_valid", 32'(if_valid), 32'h1);
      chk("flt.if_pc", if_pc, 32'h10);
      chk("flt.if_fault", 32'(if_fault), 32'h1);
      chk("flt.if_instr", if_instr, IB | 32'h10);
      chk("flt.req_valid", 32'(imem_req_valid), 32'h0);
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 0, 32'h0, 1, 0, 32'h0, 0, 1);
         chk($sformatf("halt%0d.req_valid", k), 32'(imem_req_valid), 32'h0);
         chk($sformatf("halt%0d.pc_out", k), pc_out, 32'h10);
         chk($sformatf("halt%0d.if_valid", k), 32'(if_valid), 32'h0);
      end
      drive(0, 0, 1, 32'h20, 1, 0, 32'h0, 0, 1);
      chk("resume.req_valid_halt", 32'(imem_req_valid), 32'h0);
      drive(0, 0, 0, 32'h0, 1, 0, 32'h0, 0, 1);
      chk("resume.req_valid", 32'(imem_req_valid), 32'h1);
      chk("resume.req_addr", imem_req_addr, 32'h20);
      drive(0, 0, 0, 32'h0, 0, 1, IB | 32'h20, 0, 1);

      // Delivered 0x20, then redirect to the top word to exercise PC wrap.
      drive(0, 0, 1, 32'hFFFF_FFFE, 0, 0, 32'h0, 0, 1);
      chk("resume.if_pc", if_pc, 32'h20);
      chk("resume.if_fault", 32'(if_fault), 32'h0);
      chk("resume.if_instr", if_instr, IB | 32'h20);
      drive(0, 0, 0, 32'h0, 1, 0, 32'h0, 0, 1);
      chk("wrap.req_valid", 32'(imem_req_valid), 32'h1);
      chk("wrap.req_addr", imem_req_addr, 32'hFFFF_FFFC);
      chk("wrap.if_valid_flushed", 32'(if_valid), 32'h0);
      drive(0, 0, 0, 32'h0, 0, 1, 32'h2222_0000, 0, 1);
      drive(0, 0, 0, 32'h0, 1, 0, 32'h0, 0, 1);
      chk("wrap.if_pc", if_pc, 32'hFFFF_FFFC);
      chk("wrap.if_instr", if_instr, 32'h2222_0000);
      chk("wrap.next_addr", imem_req_addr, 32'h0);
      chk("wrap.next_valid", 32'(imem_req_valid), 32'h1);

      // Reset while WAIT, then a late response must be ignored.
      drive(1, 0, 0, 32'h0, 0, 0, 32'h0, 0, 1);
      drive(1, 0, 0, 32'h0, 0, 0, 32'h0, 0, 1);
      chk("rst.req_valid", 32'(imem_req_valid), 32'h0);
      chk("rst.if_valid", 32'(if_valid), 32'h0);
      chk("rst.if_pc", if_pc, 32'h0);
      chk("rst.if_instr", if_instr, 32'h0);
      chk("rst.if_fault", 32'(if_fault), 32'h0);
      chk("rst.pc_out", pc_out, 32'h0);
      drive(0, 0, 0, 32'h0, 0, 1, 32'h5555_5555, 1, 1);
      chk("late.req_valid_hold", 32'(imem_req_valid), 32'h0);
      drive(0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 1);
      chk("late.if_valid", 32'(if_valid), 32'h0);
      chk("late.if_instr", if_instr, 32'h0);
      chk("late.req_valid", 32'(imem_req_valid), 32'h1);
      chk("late.req_addr", imem_req_addr, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Sequences instruction fetch for the core: owns the architectural fetch PC, issues one-outstanding-request reads to instruction memory, and hands {pc, instr, fault} to decode over a valid/ready handshake.
- Arbitrates next-PC sources in fixed priority: trap > branch/jump redirect > sequential +4.
- Sits between the execute-stage redirect logic, the trap unit, instruction memory and the decode stage.

Parameters:
- XLEN, 32, address and instruction width
- RESET_PC, 32'h0000_0000, fetch address after reset
- TRAP_VEC, 32'h0000_0100, fetch address on trap_valid

Ports:
- clk  input  1  clock, all state updates on the rising edge
- rst  input  1  synchronous reset, active-high
- trap_valid  input  1  take a trap; next fetch from TRAP_VEC
- branch_taken  input  1  redirect request from execute
- jump_address  input  XLEN  redirect target; bits [1:0] ignored and treated as 0
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request
- imem_req_addr  output  XLEN  fetch address, word aligned
- imem_rsp_valid  input  1  read data valid, one cycle pulse, at most one per accepted request
- imem_rsp_data  input  XLEN  instruction word
- imem_rsp_err  input  1  access fault, qualified by imem_rsp_valid
- if_valid  output  1  output buffer holds an instruction
- if_ready  input  1  decode consumes the buffer
- if_pc  output  XLEN  PC of the buffered instruction
- if_instr  output  XLEN  buffered instruction
- if_fault  output  1  buffered entry carries an access fault
- pc_out  output  XLEN  address of the next or in-flight fetch

Behaviour:
- Reset (rst=1 at an edge): state=REQ, pc=RESET_PC, buffer empty.
- Reset values of outputs: imem_req_valid=0, if_valid=0, if_pc=0, if_instr=0, if_fault=0, pc_out=RESET_PC.
- rst has priority over every other input. It aborts any in-flight fetch; a later response for that fetch is ignored while in REQ.
- State REQ:
  - imem_req_valid = !if_valid || if_ready; imem_req_addr = pc.
  - On req valid&&ready -> WAIT.
  - While not accepted, the address changes only on a redirect or trap.
- State WAIT:
  - imem_req_valid=0.
  - On rsp_valid: load the buffer {pc, rsp_data, rsp_err}, then set if_valid=1.
  - If rsp_err=0: pc <= pc+4 (mod 2^XLEN, so 32'hFFFF_FFFC wraps to 0) and go to REQ.
  - If rsp_err=1: pc unchanged, go to HALT.
- State DRAIN: an outstanding response is discarded. On rsp_valid -> REQ, nothing is buffered.
- State HALT: no requests are issued. Only a redirect or trap leaves HALT, going to REQ.
- Redirect/trap event, where ev = trap_valid || branch_taken, applies in any state:
  - pc <= TRAP_VEC if trap_valid, else {jump_address[XLEN-1:2], 2'b00}.
  - The buffer is flushed: if_valid=0 next cycle, including when it was being consumed.
  - Next state:
    - REQ with no request accepted this cycle -> REQ (new address next cycle).
    - REQ with request accepted this cycle -> DRAIN.
    - WAIT without rsp_valid -> DRAIN.
    - WAIT with rsp_valid -> REQ, response discarded.
    - DRAIN without rsp_valid -> DRAIN.
    - DRAIN with rsp_valid -> REQ.
    - HALT -> REQ.
- Output buffer: single entry. if_valid clears on if_ready when no load happens the same cycle. A load with a simultaneous consume leaves if_valid=1 with the new contents.
- pc_out = pc register.
- Latency: request issued 1 cycle after reset release; instruction visible on if_* the cycle after rsp_valid. Peak throughput is 1 instruction per 2 cycles with ready memory.

Decomposition:
- Shared package: typedef fetch_state_t {REQ, WAIT, DRAIN, HALT}, typedef fetch_pkt_t {pc, instr, fault}, and constants RESET_PC_DEFAULT / TRAP_VEC_DEFAULT.
- One natural sub-module: fetch_buffer, the single-entry valid/ready holding register with flush input.
- Next-PC priority mux and FSM stay in fetch_controller.

Test Plan:
- Reset then memory always ready with 1-cycle response, if_ready=1 -> requests to 0x0, 0x4, 0x8; if_pc sequence 0,4,8 with matching if_instr; first imem_req_valid in the cycle after rst falls.
- if_ready=0 for 5 cycles after first instruction -> if_valid stays 1, if_pc=0 stable, no new request until if_ready=1.
- Request 0x8 accepted, then branch_taken with jump_address=0xA2 before the response -> response for 0x8 is dropped, next request address 0xA0, and if_pc=0xA0 is delivered next.
- trap_valid and branch_taken asserted in the same cycle with jump_address=0x40 -> next request address 0x100 (TRAP_VEC).
- Response with rsp_err=1 at pc 0x10 -> if_fault=1 and if_pc=0x10, no further requests; then branch_taken to 0x20 -> fetch resumes at 0x20.
- Redirect to 0xFFFF_FFFC -> next fetch from 0xFFFF_FFFC, following fetch from 0x0. Also assert rst while in WAIT -> outputs return to reset values and the late response is ignored.
